// File: rtl/word_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : word_deserializer_if
// Description : Word stream in / frame stream out bundle for word_deserializer.
//               Optional DESER_FLUSH_EN adds flush_i and frame_count_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface word_deserializer_if #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 4
);
    localparam int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT;
    localparam int CNT_WIDTH   = $clog2(WORD_COUNT + 1);

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [WORD_WIDTH-1:0]  pipe_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [TOTAL_WIDTH-1:0] parallel_o;
`ifdef DESER_FLUSH_EN
    logic                   flush_i;
    logic [CNT_WIDTH-1:0]   frame_count_o;

    modport master (
        output in_valid_i, pipe_i, out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, parallel_o, frame_count_o
    );
    modport slave (
        input  in_valid_i, pipe_i, out_ready_i, flush_i,
        output in_ready_o, out_valid_o, parallel_o, frame_count_o
    );
`else
    modport master (
        output in_valid_i, pipe_i, out_ready_i,
        input  in_ready_o, out_valid_o, parallel_o
    );
    modport slave (
        input  in_valid_i, pipe_i, out_ready_i,
        output in_ready_o, out_valid_o, parallel_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : word_deserializer
// Description : Collects WORD_COUNT words (first word in the top slot) into
//               one frame on a valid/ready output. DESER_FLUSH_EN enables
//               partial-frame flush and the frame word count output.
// Revision    : 1.0 - initial release
// ============================================================================
module word_deserializer #(
    parameter int WORD_WIDTH  = 8,
    parameter int WORD_COUNT  = 4,
    parameter int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT,
    parameter int CNT_WIDTH   = $clog2(WORD_COUNT + 1)
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    word_deserializer_if.slave  deser
);

    localparam logic [0:0]           c_ST_FILL  = 1'b0;
    localparam logic [0:0]           c_ST_FULL  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_LAST_IDX = CNT_WIDTH'(WORD_COUNT - 1);

    logic [0:0]             r_state;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [TOTAL_WIDTH-1:0] r_data;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_handoff;
    logic                   w_last_word;
    logic                   w_flush;
    logic                   w_close;
    logic [TOTAL_WIDTH-1:0] w_fill_data;
    logic [TOTAL_WIDTH-1:0] w_first_data;

    // in_ready is a pure function of state, reset and out_ready so the
    // upstream never sees a combinational path from its own valid.
    assign w_in_ready  = !rst_i && ((r_state == c_ST_FILL) || deser.out_ready_i);
    assign w_accept    = deser.in_valid_i && w_in_ready;
    assign w_handoff   = (r_state == c_ST_FULL) && deser.out_ready_i;
    assign w_last_word = w_accept && (r_count == c_LAST_IDX);

`ifdef DESER_FLUSH_EN
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [CNT_WIDTH-1:0] w_frame_words;

    assign w_flush       = deser.flush_i && ((r_count != '0) || w_accept);
    assign w_frame_words = r_count + CNT_WIDTH'(w_accept);
    assign deser.frame_count_o = r_frame_count;
`else
    assign w_flush = 1'b0;
`endif

    assign w_close = w_last_word || w_flush;

    always_comb begin
        w_fill_data = r_data;
        for (int k = 0; k < WORD_COUNT; k++) begin
            if (r_count == CNT_WIDTH'(k)) begin
                w_fill_data[(WORD_COUNT-1-k)*WORD_WIDTH +: WORD_WIDTH] = deser.pipe_i;
            end
        end
    end

    assign w_first_data = {deser.pipe_i, {(TOTAL_WIDTH-WORD_WIDTH){1'b0}}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_FILL;
            r_count <= '0;
            r_data  <= '0;
`ifdef DESER_FLUSH_EN
            r_frame_count <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_accept) begin
                        r_data  <= w_fill_data;
                        r_count <= r_count + CNT_WIDTH'(1);
                    end
                    if (w_close) begin
                        r_state <= c_ST_FULL;
                        r_count <= '0;
`ifdef DESER_FLUSH_EN
                        r_frame_count <= w_frame_words;
`endif
                    end
                end
                c_ST_FULL: begin
                    // A new word may land in the top slot on the same edge
                    // the held frame leaves, keeping one word per cycle.
                    if (w_handoff) begin
                        r_state <= c_ST_FILL;
                        if (w_accept) begin
                            r_data  <= w_first_data;
                            r_count <= CNT_WIDTH'(1);
                        end else begin
                            r_data  <= '0;
                            r_count <= '0;
                        end
`ifdef DESER_FLUSH_EN
                        r_frame_count <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= c_ST_FILL;
                end
            endcase
        end
    end

    assign deser.in_ready_o  = w_in_ready;
    assign deser.out_valid_o = (r_state == c_ST_FULL);
    assign deser.parallel_o  = r_data;

endmodule
`default_nettype wire
